k_vote: RTL and testbench
=========================

Name: k_vote

Overview:
- Parametrised successor to the KNN majority-vote stage. It sits after the k-nearest sorter and takes K neighbour class labels, packed nearest-first.
- It counts votes per class and scans for the winner. A tie-break mode is selectable, and out-of-range labels are rejected.
- Results leave on a valid/ready handshake, so the classifier back-end can stall the block.

Parameters:
- K, 8: number of neighbour labels per request; must be ≥1.
- TYPE_W, 3: label width in bits.
- NUM_CLASSES, 1<<TYPE_W: number of legal classes, 1..2^TYPE_W. Labels ≥NUM_CLASSES are ignored.
- TIE_MODE, 0: 0 = lowest class index wins a tie; 1 = the tied class whose first occurrence is nearest (lowest slot) wins.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: a request is present.
- in_ready, out, 1: block can accept a request; high only in IDLE.
- k_nearest_neighbours_type, in, TYPE_W*K: packed labels; slot j is bits [(j+1)*TYPE_W-1 -: TYPE_W]; slot 0 is the nearest.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- inferred_type, out, TYPE_W: winning class.
- rejected_cnt, out, clog2(K+1): number of labels ignored as ≥NUM_CLASSES.

Behaviour:
- One clock, clk; synchronous active-high reset, rst. Reset has priority over all other activity.
- Reset values:
  - state = IDLE; out_valid = 0; inferred_type = 0; rejected_cnt = 0.
  - All per-class counts = 0; all first-occurrence registers = K.
  - in_ready = 1 in the cycle after reset deasserts.
- Count width is CW = clog2(K+1). Per-class counts and rejected_cnt saturate at K, which cannot be exceeded by design.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture the whole label vector into an internal register, clear counts and first-occurrence registers, set j = 0, go to COUNT.
  - The label input is not sampled again until the next IDLE.
- COUNT: one slot per cycle, j = 0..K-1.
  - If label < NUM_CLASSES: increment its count; if its first-occurrence register is still K, load it with j.
  - Otherwise: increment rejected_cnt.
  - After slot K-1: set j = 0, best = 0, go to SCAN.
- SCAN: one class per cycle, c = 0..NUM_CLASSES-1.
  - Replace best with c if count[c] > count[best].
  - With TIE_MODE = 1, also replace best with c if count[c] == count[best] and first[c] < first[best].
  - On the last class: load inferred_type with the final best (including the same-cycle comparison), set out_valid = 1, go to DONE.
- DONE:
  - out_valid, inferred_type and rejected_cnt are held stable while out_ready = 0.
  - On out_valid & out_ready: out_valid = 0, go to IDLE.
- Latency:
  - The acceptance edge takes the block to COUNT.
  - out_valid rises on the K + NUM_CLASSES-th rising edge after the acceptance edge.
  - Minimum request spacing is K + NUM_CLASSES + 2 cycles when out_ready is held at 1.
- All labels rejected: every count is 0; inferred_type = 0; rejected_cnt = K.
- in_valid while busy: ignored (in_ready = 0). The upstream source must hold the request until it is accepted.
- Reset mid-operation: aborts immediately; no result is emitted; the next request is processed cleanly.
- out_ready asserted while out_valid = 0 has no effect.

Optional Feature:
- Macro: K_VOTE_CONFIDENCE_EN.
- Defined: adds output ports vote_count [CW-1:0] and tie_flag [0:0], both registered alongside inferred_type and held in DONE.
  - vote_count = count of the winning class.
  - tie_flag = 1 if any other class had a count equal to the winner's; it is also 1 when all classes have zero votes.
  - Both reset to 0.
- Undefined: neither port exists, and no confidence logic is synthesised.

Test Plan:
- Majority (K=8, TYPE_W=3, TIE_MODE=0), out_ready=1:
  - Stimulus: labels slot0..7 = 2,5,2,1,2,5,0,2.
  - Response: inferred_type = 2, rejected_cnt = 0; out_valid rises exactly 16 edges after acceptance.
- Tie, TIE_MODE=0:
  - Stimulus: labels 6,6,3,3,1,0,7,4.
  - Response: inferred_type = 3 (lower index); with K_VOTE_CONFIDENCE_EN: vote_count = 2, tie_flag = 1.
- Tie, TIE_MODE=1, same labels as the previous scenario:
  - Response: inferred_type = 6 (first seen at slot 0).
- Rejection (NUM_CLASSES=5):
  - Stimulus: labels 7,7,7,6,1,1,5,0.
  - Response: inferred_type = 1, rejected_cnt = 5.
  - Second stimulus: all labels = 7. Response: inferred_type = 0, rejected_cnt = 8.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid rises, with in_valid held high throughout.
  - Response: outputs remain stable, in_ready = 0, no second request is accepted; the second request is accepted 1 cycle after the out_ready handshake.
- Reset mid-operation:
  - Stimulus: assert rst during SCAN, then submit labels 4×8.
  - Response: out_valid stays 0 through the reset; the following result is inferred_type = 4 with no stale counts.

Source files
------------

// File: rtl/k_vote.sv
// k_vote: KNN majority vote over K packed labels, count/scan FSM with valid/ready result.
// Define K_VOTE_CONFIDENCE_EN to add the vote_count and tie_flag outputs.
module k_vote #(
    parameter int K = 8,
    parameter int TYPE_W = 3,
    parameter int NUM_CLASSES = 1 << TYPE_W,
    parameter int TIE_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TYPE_W*K-1:0]       k_nearest_neighbours_type,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TYPE_W-1:0]         inferred_type,
    output logic [$clog2(K+1)-1:0]    rejected_cnt
`ifdef K_VOTE_CONFIDENCE_EN
    ,
    output logic [$clog2(K+1)-1:0]    vote_count,
    output logic [0:0]                tie_flag
`endif
);
    localparam int CW = $clog2(K + 1);
    localparam int IW = $clog2((K > NUM_CLASSES ? K : NUM_CLASSES) + 1);
    localparam int AW = NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

    state_t              state, state_nx;
    logic [TYPE_W*K-1:0] labels;
    logic [CW-1:0]       cnt   [NUM_CLASSES];
    logic [CW-1:0]       first [NUM_CLASSES];
    logic [IW-1:0]       idx;
    logic [AW-1:0]       best, best_nx, cls, lab_a;
    logic [TYPE_W-1:0]   lab;
    logic                lab_ok, last_slot, last_cls, better;

    assign lab       = labels[idx*TYPE_W +: TYPE_W];
    assign lab_ok    = int'(lab) < NUM_CLASSES;
    assign lab_a     = AW'(lab);
    assign cls       = AW'(idx);
    assign last_slot = idx == IW'(K - 1);
    assign last_cls  = idx == IW'(NUM_CLASSES - 1);
    // first[] only breaks ties between equal counts, never overrides a higher count
    assign better    = cnt[cls] > cnt[best] ||
                       (TIE_MODE != 0 && cnt[cls] == cnt[best] && first[cls] < first[best]);
    assign best_nx   = better ? cls : best;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid  ? COUNT : IDLE;
            COUNT:   state_nx = last_slot ? SCAN  : COUNT;
            SCAN:    state_nx = last_cls  ? DONE  : SCAN;
            default: state_nx = out_ready ? IDLE  : DONE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

`ifdef K_VOTE_CONFIDENCE_EN
    logic tie_nx;
    always_comb begin
        tie_nx = cnt[best_nx] == '0;
        for (int c = 0; c < NUM_CLASSES; c++)
            tie_nx = tie_nx | (AW'(c) != best_nx && cnt[c] == cnt[best_nx]);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            labels        <= '0;
            cnt           <= '{default: '0};
            first         <= '{default: CW'(K)};
            idx           <= '0;
            best          <= '0;
            inferred_type <= '0;
            rejected_cnt  <= '0;
`ifdef K_VOTE_CONFIDENCE_EN
            vote_count    <= '0;
            tie_flag      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    labels       <= k_nearest_neighbours_type;
                    cnt          <= '{default: '0};
                    first        <= '{default: CW'(K)};
                    rejected_cnt <= '0;
                    idx          <= '0;
                end
                COUNT: begin
                    if (lab_ok) begin
                        cnt[lab_a] <= cnt[lab_a] + CW'(1);
                        if (first[lab_a] == CW'(K))
                            first[lab_a] <= CW'(idx);
                    end else begin
                        rejected_cnt <= rejected_cnt + CW'(1);
                    end
                    idx  <= last_slot ? '0 : idx + IW'(1);
                    best <= '0;
                end
                SCAN: begin
                    best <= best_nx;
                    idx  <= idx + IW'(1);
                    if (last_cls) begin
                        inferred_type <= TYPE_W'(best_nx);
`ifdef K_VOTE_CONFIDENCE_EN
                        vote_count    <= cnt[best_nx];
                        tie_flag      <= tie_nx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_k_vote.sv
// tb_k_vote: three k_vote instances (lowest-index ties, nearest-first ties, 5 classes) checked by a scoreboard.
module tb_k_vote;
    localparam int K  = 8;
    localparam int TW = 3;

    typedef struct {
        int t;
        int r;
        int vc;
        int tie;
    } exp_t;

    logic          clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [TW*K-1:0] labels = '0;
    logic          ir [3];
    logic          ov [3];
    logic [TW-1:0] inf [3];
    logic [3:0]    rej [3];
`ifdef K_VOTE_CONFIDENCE_EN
    logic [3:0]    vc [3];
    logic [0:0]    tf [3];
`endif

    int   cmp = 0, err = 0, cyc = 0, acc = 0;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Winner = class with the most votes; ties go to lowest index or earliest first sighting
    function automatic exp_t model(input logic [TW*K-1:0] v, input int nc, input int tm);
        int cnt[8], fst[8], mx, n_at_max, l;
        exp_t e;
        e.r = 0;
        for (int c = 0; c < 8; c++) begin cnt[c] = 0; fst[c] = K; end
        for (int s = 0; s < K; s++) begin
            l = int'(v[s*TW +: TW]);
            if (l < nc) begin
                cnt[l]++;
                if (fst[l] == K) fst[l] = s;
            end else e.r++;
        end
        mx = 0;
        for (int c = 0; c < nc; c++) if (cnt[c] > mx) mx = cnt[c];
        e.t = -1;
        n_at_max = 0;
        for (int c = 0; c < nc; c++) begin
            if (cnt[c] != mx) continue;
            n_at_max++;
            if (e.t < 0 || (tm == 1 && fst[c] < fst[e.t])) e.t = c;
        end
        e.vc  = mx;
        e.tie = (n_at_max > 1 || mx == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic int qsize(input int i);
        return i == 0 ? q0.size() : i == 1 ? q1.size() : q2.size();
    endfunction

    function automatic exp_t front(input int i);
        return i == 0 ? q0[0] : i == 1 ? q1[0] : q2[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else if (i == 1) void'(q1.pop_front());
        else void'(q2.pop_front());
    endtask

    task automatic push_all(input logic [TW*K-1:0] v);
        acc = cyc;
        q0.push_back(model(v, 8, 0));
        q1.push_back(model(v, 8, 1));
        q2.push_back(model(v, 5, 0));
    endtask

    for (genvar i = 0; i < 3; i++) begin : g
        k_vote #(.K(K), .TYPE_W(TW), .NUM_CLASSES(i == 2 ? 5 : 8), .TIE_MODE(i == 1 ? 1 : 0)) dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid),
            .in_ready(ir[i]),
            .k_nearest_neighbours_type(labels),
            .out_valid(ov[i]),
            .out_ready(out_ready),
            .inferred_type(inf[i]),
            .rejected_cnt(rej[i])
`ifdef K_VOTE_CONFIDENCE_EN
            ,
            .vote_count(vc[i]),
            .tie_flag(tf[i])
`endif
        );

        logic pv = 0;
        exp_t e;
        always @(negedge clk) begin
            if (!rst) begin
                if (ov[i] && !pv)
                    chk($sformatf("latency[%0d]", i), cyc - acc, K + (i == 2 ? 5 : 8));
                if (ov[i]) begin
                    if (qsize(i) == 0) chk($sformatf("unexpected_out[%0d]", i), 1, 0);
                    else begin
                        e = front(i);
                        chk($sformatf("inferred_type[%0d]", i), int'(inf[i]), e.t);
                        chk($sformatf("rejected_cnt[%0d]", i), int'(rej[i]), e.r);
`ifdef K_VOTE_CONFIDENCE_EN
                        chk($sformatf("vote_count[%0d]", i), int'(vc[i]), e.vc);
                        chk($sformatf("tie_flag[%0d]", i), int'(tf[i]), e.tie);
`endif
                        if (out_ready) qpop(i);
                    end
                end
            end
            pv = ov[i];
        end
    end

    function automatic logic [TW*K-1:0] pack(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {TW'(a7), TW'(a6), TW'(a5), TW'(a4), TW'(a3), TW'(a2), TW'(a1), TW'(a0)};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!(ir[0] && ir[1] && ir[2]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("idle_timeout", n, 0);
    endtask

    task automatic issue(input logic [TW*K-1:0] v);
        wait_idle();
        labels   = v;
        in_valid = 1;
        @(posedge clk);
        #1;
        push_all(v);
        in_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [TW*K-1:0] v, v2;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_in_ready[%0d]", i), int'(ir[i]), 1);
            chk($sformatf("reset_out_valid[%0d]", i), int'(ov[i]), 0);
            chk($sformatf("reset_inferred[%0d]", i), int'(inf[i]), 0);
            chk($sformatf("reset_rejected[%0d]", i), int'(rej[i]), 0);
        end

        issue(pack(2, 5, 2, 1, 2, 5, 0, 2));
        issue(pack(6, 6, 3, 3, 1, 0, 7, 4));
        issue(pack(7, 7, 7, 6, 1, 1, 5, 0));
        issue(pack(7, 7, 7, 7, 7, 7, 7, 7));
        issue(pack(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (30) begin
            for (int s = 0; s < K; s++) v[s*TW +: TW] = TW'($urandom_range(0, 7));
            issue(v);
        end

        // Backpressure with a second request held pending throughout
        v  = pack(3, 1, 3, 6, 6, 3, 2, 6);
        v2 = pack(5, 5, 1, 1, 0, 4, 4, 4);
        wait_idle();
        labels   = v;
        in_valid = 1;
        @(posedge clk);
        #1;
        push_all(v);
        in_valid  = 0;
        out_ready = 0;
        n = 0;
        while (!(ov[0] && ov[1] && ov[2]) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 100) chk("bp_valid_timeout", n, 0);
        labels   = v2;
        in_valid = 1;
        repeat (10) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) chk($sformatf("bp_in_ready[%0d]", i), int'(ir[i]), 0);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_release_ready[%0d]", i), int'(ir[i]), 1);
            chk($sformatf("bp_release_valid[%0d]", i), int'(ov[i]), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("bp_accept[%0d]", i), int'(ir[i]), 0);
        push_all(v2);
        in_valid = 0;

        // Reset in the middle of SCAN
        issue(pack(1, 2, 3, 1, 2, 3, 1, 0));
        repeat (K + 3) @(posedge clk);
        #1 rst = 1;
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk($sformatf("rst_out_valid[%0d]", i), int'(ov[i]), 0);
        end
        @(posedge clk);
        #1 rst = 0;
        issue(pack(4, 4, 4, 4, 4, 4, 4, 4));

        wait_idle();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("drain[%0d]", i), qsize(i), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
